// File: rtl/dpctrl_pkg.sv
// -----------------------------------------------------------------------------
// dpctrl_pkg
// Shared definitions for the datapath instruction sequencer:
//   - sequencer state encoding
//   - instruction class produced by the decoder
//   - opcode / op field constants
//   - ALUop and shifter encodings
//   - instruction field bit positions
//   - a small sign-extension helper for the 8-bit immediate
// Optional feature macro used by the sequencer files: DPCTRL_STATUS_EN
// -----------------------------------------------------------------------------
package dpctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_EXEC      = 3'd4,
    ST_WRITE_REG = 3'd5,
    ST_WRITE_IMM = 3'd6
  } state_e;

  // Instruction class: groups instructions that share a state path.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ALU_AB  = 3'd3,  // ADD / AND: read Rn and Rm, write Rd
    CLS_CMP     = 3'd4,
    CLS_MVN     = 3'd5
  } icls_e;

  // Opcode field values
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field values under OPC_MOV
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  // op field values under OPC_ALU
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // ALUop encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_NOT_B = 2'b11;

  // Shifter encodings
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Instruction field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/dpctrl_decode.sv
// -----------------------------------------------------------------------------
// dpctrl_decode
// Purely combinational instruction decoder for the datapath sequencer.
// Ports:
//   ir_i       in  16  captured instruction
//   cls_o      out  3  instruction class (icls_e encoding)
//   rn_o       out  3  Rn field
//   rd_o       out  3  Rd field
//   rm_o       out  3  Rm field
//   sh_o       out  2  shift field
//   aluop_o    out  2  ALU operation for the EXEC step
//   illegal_o  out  1  opcode/op combination not supported
//   imm_o      out 16  sign-extended imm8
// Macro DPCTRL_STATUS_EN: when defined, 101/01 decodes as CMP; otherwise illegal.
// -----------------------------------------------------------------------------
module dpctrl_decode
  import dpctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  cls_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  sh_o,
  output logic [1:0]  aluop_o,
  output logic        illegal_o,
  output logic [15:0] imm_o
);

  logic [2:0] opc;
  logic [1:0] op;
  icls_e      cls;
  logic [1:0] aluop;

  assign opc   = ir_i[OPC_HI:OPC_LO];
  assign op    = ir_i[OP_HI:OP_LO];
  assign rn_o  = ir_i[RN_HI:RN_LO];
  assign rd_o  = ir_i[RD_HI:RD_LO];
  assign rm_o  = ir_i[RM_HI:RM_LO];
  assign sh_o  = ir_i[SH_HI:SH_LO];
  assign imm_o = sext8(ir_i[IMM_HI:IMM_LO]);

  always_comb begin
    cls   = CLS_ILLEGAL;
    aluop = ALU_ADD;
    case (opc)
      OPC_MOV: begin
        // MOV reg runs through the ALU as 0 + (Rm shifted), so ADD.
        if (op == OP_MOV_IMM) begin
          cls = CLS_MOV_IMM;
        end else if (op == OP_MOV_REG) begin
          cls = CLS_MOV_REG;
        end
      end
      OPC_ALU: begin
        case (op)
          OP_ADD: begin
            cls   = CLS_ALU_AB;
            aluop = ALU_ADD;
          end
          OP_AND: begin
            cls   = CLS_ALU_AB;
            aluop = ALU_AND;
          end
          OP_MVN: begin
            cls   = CLS_MVN;
            aluop = ALU_NOT_B;
          end
          OP_CMP: begin
`ifdef DPCTRL_STATUS_EN
            cls   = CLS_CMP;
            aluop = ALU_SUB;
`else
            cls   = CLS_ILLEGAL;
`endif
          end
          default: cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign cls_o     = cls;
  assign aluop_o   = aluop;
  assign illegal_o = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
// Instruction sequencer for the 16-bit register/shift/ALU datapath. Accepts an
// instruction on start (in WAIT), then steps the datapath through register
// read, execute and writeback, finishing with a one-cycle done pulse.
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous active-high, returns to WAIT, clears ir
//   start        in   1  request, sampled only in WAIT
//   instr        in  16  instruction captured on an accepted start
//   busy         out  1  high in every state except WAIT
//   done         out  1  high in the final state of an instruction
//   illegal      out  1  high with done for an unsupported opcode
//   datapath_in  out 16  sign-extended ir[7:0]
//   readnum      out  3  register-read index (0 when unused)
//   writenum     out  3  register-write index (0 when unused)
//   loada/loadb/loadc/loads/write/vsel/asel/bsel  out 1  datapath enables
//   shift        out  2  shifter op (ir[4:3] in EXEC, else 0)
//   ALUop        out  2  ALU op (0 outside EXEC)
// Macro DPCTRL_STATUS_EN: enables CMP and its loads pulse; when undefined
// loads is constant 0 and 101/01 is illegal.
// All control outputs are Moore outputs of state and ir, so the asynchronous
// reset clears them immediately.
// -----------------------------------------------------------------------------
module datapath_ctrl
  import dpctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] datapath_in,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        vsel,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0]  dec_cls_raw;
  icls_e       dec_cls;
  logic [2:0]  dec_rn;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_rm;
  logic [1:0]  dec_sh;
  logic [1:0]  dec_aluop;
  logic        dec_illegal;
  logic [15:0] dec_imm;

  dpctrl_decode u_decode (
    .ir_i      (ir_q),
    .cls_o     (dec_cls_raw),
    .rn_o      (dec_rn),
    .rd_o      (dec_rd),
    .rm_o      (dec_rm),
    .sh_o      (dec_sh),
    .aluop_o   (dec_aluop),
    .illegal_o (dec_illegal),
    .imm_o     (dec_imm)
  );

  assign dec_cls = icls_e'(dec_cls_raw);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // ir only loads in WAIT, so it is stable for the whole instruction.
  assign busy        = (state_q != ST_WAIT);
  assign datapath_in = dec_imm;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    done     = 1'b0;
    illegal  = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    vsel     = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;

    case (state_q)
      ST_WAIT: begin
        if (start) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (dec_cls)
          CLS_MOV_IMM:         state_d = ST_WRITE_IMM;
          CLS_ALU_AB, CLS_CMP: state_d = ST_GET_A;
          CLS_MOV_REG, CLS_MVN: state_d = ST_GET_B;
          default: begin
            done    = 1'b1;
            illegal = dec_illegal;
            state_d = ST_WAIT;
          end
        endcase
      end

      ST_GET_A: begin
        readnum = dec_rn;
        loada   = 1'b1;
        state_d = ST_GET_B;
      end

      ST_GET_B: begin
        readnum = dec_rm;
        loadb   = 1'b1;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        // MOV reg forces the A operand to zero so ADD passes B through.
        asel  = (dec_cls == CLS_MOV_REG);
        shift = dec_sh;
        ALUop = dec_aluop;
        loadc = 1'b1;
        if (dec_cls == CLS_CMP) begin
`ifdef DPCTRL_STATUS_EN
          loads = 1'b1;
`endif
          done    = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_WRITE_REG;
        end
      end

      ST_WRITE_REG: begin
        writenum = dec_rd;
        write    = 1'b1;
        done     = 1'b1;
        state_d  = ST_WAIT;
      end

      ST_WRITE_IMM: begin
        writenum = dec_rn;
        vsel     = 1'b1;
        write    = 1'b1;
        done     = 1'b1;
        state_d  = ST_WAIT;
      end

      default: state_d = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl
// Scoreboard bench for datapath_ctrl. A reference model expands each issued
// instruction into its expected per-cycle control vectors; a monitor compares
// every busy cycle against the queue and every idle cycle against an all-quiet
// vector. Honours DPCTRL_STATUS_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        busy, done, illegal;
  logic [15:0] datapath_in;
  logic [2:0]  readnum, writenum;
  logic        loada, loadb, loadc, loads, write, vsel, asel, bsel;
  logic [1:0]  shift, ALUop;

  datapath_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .datapath_in (datapath_in),
    .readnum     (readnum),
    .writenum    (writenum),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .write       (write),
    .vsel        (vsel),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .ALUop       (ALUop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        vsel;
    logic        asel;
    logic        bsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] dp_in;
  } vec_t;

  vec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_ir = 16'h0000;
  bit          mon_en = 1'b0;

  function automatic vec_t act_vec();
    vec_t v;
    v.busy = busy; v.done = done; v.illegal = illegal;
    v.loada = loada; v.loadb = loadb; v.loadc = loadc; v.loads = loads;
    v.write = write; v.vsel = vsel; v.asel = asel; v.bsel = bsel;
    v.readnum = readnum; v.writenum = writenum;
    v.shift = shift; v.aluop = ALUop; v.dp_in = datapath_in;
    return v;
  endfunction

  function automatic logic [15:0] sx(input logic [15:0] ir);
    int s;
    s = int'(ir[7:0]);
    if (s >= 128) s = s - 256;
    return 16'(s);
  endfunction

  function automatic vec_t idle_vec(input logic [15:0] ir);
    vec_t v;
    v = '0;
    v.dp_in = sx(ir);
    return v;
  endfunction

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: expands one instruction into the sequence of control
  // vectors expected on the cycles after acceptance.
  task automatic push_model(input logic [15:0] ir);
    int   opc, op, rn, rd, rm, sh, alu;
    bit   legal, movimm, movreg, cmp, needs_a;
    vec_t base, v;
    opc = int'(ir) / 8192;
    op  = (int'(ir) / 2048) % 4;
    rn  = (int'(ir) / 256) % 8;
    rd  = (int'(ir) / 32) % 8;
    sh  = (int'(ir) / 8) % 4;
    rm  = int'(ir) % 8;
    legal = 0; movimm = 0; movreg = 0; cmp = 0; needs_a = 0; alu = 0;
    if (opc == 6 && op == 2) begin legal = 1; movimm = 1; end
    else if (opc == 6 && op == 0) begin legal = 1; movreg = 1; alu = 0; end
    else if (opc == 5) begin
      if (op == 0) begin legal = 1; needs_a = 1; alu = 0; end
      else if (op == 2) begin legal = 1; needs_a = 1; alu = 2; end
      else if (op == 3) begin legal = 1; alu = 3; end
      else begin
`ifdef DPCTRL_STATUS_EN
        legal = 1; needs_a = 1; cmp = 1; alu = 1;
`endif
      end
    end

    base = '0;
    base.busy = 1'b1;
    base.dp_in = sx(ir);

    v = base;
    if (!legal) begin
      v.done = 1'b1;
      v.illegal = 1'b1;
      exp_q.push_back(v);
      return;
    end
    exp_q.push_back(v);

    if (!movimm) begin
      if (needs_a) begin
        v = base; v.readnum = 3'(rn); v.loada = 1'b1;
        exp_q.push_back(v);
      end
      v = base; v.readnum = 3'(rm); v.loadb = 1'b1;
      exp_q.push_back(v);
      v = base; v.asel = movreg; v.shift = 2'(sh); v.aluop = 2'(alu); v.loadc = 1'b1;
      if (cmp) begin
        v.loads = 1'b1;
        v.done = 1'b1;
        exp_q.push_back(v);
        return;
      end
      exp_q.push_back(v);
    end

    v = base;
    v.write = 1'b1;
    v.done = 1'b1;
    v.vsel = movimm;
    v.writenum = movimm ? 3'(rn) : 3'(rd);
    exp_q.push_back(v);
  endtask

  // Monitor: every clock, busy cycles consume an expected vector; idle cycles
  // must be completely quiet.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_busy t=%0t actual=%h required=idle", $time, act_vec());
        end else begin
          check_vec("cycle", act_vec(), exp_q.pop_front());
        end
      end else begin
        check_vec("idle", act_vec(), idle_vec(last_ir));
      end
    end
  end

  // Entry condition: just after a negedge while the DUT sits in WAIT.
  task automatic issue(input logic [15:0] ir, input int gap, input bit hold);
    bit drained;
    for (int g = 0; g < gap; g++) begin
      start = 1'b0;
      @(negedge clk); #1;
    end
    start = 1'b1;
    instr = ir;
    push_model(ir);
    @(posedge clk); #1;
    last_ir = ir;
    drained = 1'b0;
    for (int c = 0; c < 12; c++) begin
      // start/instr churn while busy must have no effect
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      instr = 16'($urandom);
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout t=%0t actual=%0d required=0 (pending vectors)", $time, exp_q.size());
      exp_q.delete();
    end
    start = hold;
    @(negedge clk); #1;
  endtask

  logic [4:0] tops [6];
  logic [15:0] dir [8];

  initial begin
    tops[0] = 5'b11010; tops[1] = 5'b11000; tops[2] = 5'b10100;
    tops[3] = 5'b10101; tops[4] = 5'b10110; tops[5] = 5'b10111;
    dir[0] = 16'hD007; dir[1] = 16'hD1FE; dir[2] = 16'hA148; dir[3] = 16'hA900;
    dir[4] = 16'h0000; dir[5] = 16'hC0B2; dir[6] = 16'hB8F5; dir[7] = 16'hB36A;

    // Asynchronous reset with no clock edge yet
    #1 reset = 1'b1;
    #1;
    check_vec("reset_outputs", act_vec(), '0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) begin @(negedge clk); #1; end

    // Directed instructions from the plan
    for (int i = 0; i < 8; i++) issue(dir[i], 0, 1'b0);

    // Reset in the middle of GET_B
    start = 1'b1;
    instr = 16'hA148;
    push_model(16'hA148);
    @(posedge clk); #1;
    last_ir = 16'hA148;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check_val("pre_reset_loadb", {15'd0, loadb}, 16'd1);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rst_busy", {15'd0, busy}, 16'd0);
    check_val("rst_loadb", {15'd0, loadb}, 16'd0);
    check_val("rst_readnum", {13'd0, readnum}, 16'd0);
    check_val("rst_done", {15'd0, done}, 16'd0);
    check_val("rst_write", {15'd0, write}, 16'd0);
    check_val("rst_dp_in", datapath_in, 16'd0);
    exp_q.delete();
    last_ir = 16'h0000;
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (4) begin @(negedge clk); #1; end

    // Randomized traffic, mostly legal encodings with random fields
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      if ($urandom_range(0, 9) < 7) ir[15:11] = tops[$urandom_range(0, 5)];
      issue(ir, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (3) begin @(negedge clk); #1; end

    check_val("queue_empty", 16'(exp_q.size()), 16'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Instruction sequencer for the 16-bit register/shift/ALU datapath. It accepts one instruction on a start handshake and steps the datapath through register read, execute and writeback. It drives every datapath control input (readnum, writenum, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, vsel, write, datapath_in) in place of the manual switch interface. It signals completion with a one-cycle done pulse.

## Interface
- No parameters; all widths fixed.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; returns block to WAIT
- start  in  1  request; sampled only in WAIT
- instr  in  16  instruction, captured into ir on an accepted start
- busy  out  1  high in every state except WAIT
- done  out  1  high during the final state of an instruction
- illegal  out  1  high with done when the opcode is unsupported
- datapath_in  out  16  sign-extended ir[7:0]
- readnum  out  3  register-read index; 0 when unused
- writenum  out  3  register-write index; 0 when unused
- loada, loadb, loadc, loads, write, vsel, asel, bsel  out  1 each  datapath enables/selects
- shift  out  2  shifter op; equals ir[4:3] in EXEC, otherwise 0
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT B; 0 outside EXEC

## Operation
- Encoding: opcode ir[15:13], op ir[12:11], Rn ir[10:8], Rd ir[7:5], sh ir[4:3], Rm ir[2:0], imm8 ir[7:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}
  - Any other opcode/op combination is illegal.
- States:
  - WAIT: no outputs asserted. If start is high, capture ir and go to DECODE.
  - DECODE: no controls asserted.
    - MOV imm goes to WRITE_IMM.
    - ADD, AND, CMP go to GET_A.
    - MOV reg, MVN go to GET_B.
    - Illegal: assert done and illegal, go to WAIT.
  - GET_A: readnum=Rn, loada=1. Next state GET_B.
  - GET_B: readnum=Rm, loadb=1. Next state EXEC.
  - EXEC: asel=1 for MOV reg (A forced to 0), otherwise asel=0; bsel=0; shift=sh; ALUop per table (MOV reg uses ADD, CMP uses SUB); loadc=1.
    - CMP: loads=1 and done=1, next state WAIT.
    - All others: next state WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=0, write=1, done=1. Next state WAIT.
  - WRITE_IMM: writenum=Rn, vsel=1, write=1, done=1. Next state WAIT.
- All controls are Moore outputs decoded from state and ir only.
- start is ignored outside WAIT; ir does not change while busy.
- A start held continuously issues back-to-back instructions, with one WAIT cycle between them.

## Timing
- Start is accepted at edge T0. Done is high in:
  - cycle T2 for MOV imm
  - T4 for MOV reg and MVN
  - T4 for CMP
  - T5 for ADD and AND
  - T1 for an illegal opcode
- The datapath performs the write/load on the rising edge that ends the asserted cycle.
- Reset, including mid-instruction:
  - state=WAIT, ir=0.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - No partial write is issued after reset deasserts.

## Configuration
- DPCTRL_STATUS_EN defined: CMP is supported and loads is asserted in its EXEC cycle.
- Undefined:
  - 101/01 is decoded as illegal.
  - loads is tied to 0 in every state.
  - ADD, AND and MVN never assert loads, with or without the macro.

## Structure
- Package dpctrl_pkg holds:
  - the state enum (WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM)
  - opcode/op constants
  - ALUop and shift encodings
  - field-position constants
- One sub-module: dpctrl_decode, a combinational block. It takes ir and produces the instruction class, register fields, ALUop, an illegal flag and sign-extended imm8. The state register and output decode stay in datapath_ctrl.

## Test plan
- Reset asserted mid-GET_B -> busy, loadb, readnum, done all 0 before the next edge; after release, WAIT holds until start.
- start with instr=16'hD007 (MOV R0,#7) -> T2: write=1, vsel=1, writenum=0, datapath_in=16'h0007, done=1; T3 busy=0.
- instr=16'hD1FE (MOV R1,#-2) -> WRITE_IMM: datapath_in=16'hFFFE, writenum=1.
- instr=16'hA148 (ADD R2,R1,R0 LSL) -> T2 readnum=1/loada; T3 readnum=0/loadb; T4 shift=01, ALUop=00, loadc=1; T5 writenum=2, write=1, done=1. A start pulse during T3 is ignored.
- instr=16'hA900 (CMP R1,R0) with macro -> T4: ALUop=01, loadc=1, loads=1, done=1, no write cycle. Without macro -> T1: done=1, illegal=1.
- instr=16'h0000 -> T1: done=1, illegal=1, no load/write asserted in any cycle.
